// File: rtl/sync_memory_pkg.sv
// sync_memory_pkg: shared defaults, types and depth for the sync_memory scratch RAM
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF / RESET_VALUE_DEF : default geometry and reset fill value
//   DEPTH_DEF                                         : number of locations, 2**ADDR_WIDTH_DEF
//   addr_t / data_t                                   : address and data word types at default geometry
package sync_memory_pkg;
   localparam int ADDR_WIDTH_DEF = 2;
   localparam int DATA_WIDTH_DEF = 8;
   localparam logic [DATA_WIDTH_DEF-1:0] RESET_VALUE_DEF = 8'hFF;
   localparam int DEPTH_DEF = 2 ** ADDR_WIDTH_DEF;
   typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
   typedef logic [DATA_WIDTH_DEF-1:0] data_t;
endpackage

// File: rtl/sync_memory_if.sv
// sync_memory_if: request/response bundle between a memory user and sync_memory
//   addr    : location for this cycle's write and/or read
//   wr_en   : write strobe, wr_data stored at addr on the rising edge
//   rd_en   : read strobe, rd_data loaded from addr on the rising edge
//   wr_data : write data
//   rd_data : registered read data
//   modports: master (memory user), slave (memory)
interface sync_memory_if
   import sync_memory_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();
   logic [ADDR_WIDTH-1:0] addr;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] rd_data;
   modport master (output addr, output wr_en, output rd_en, output wr_data, input rd_data);
   modport slave (input addr, input wr_en, input rd_en, input wr_data, output rd_data);
endinterface

// File: rtl/sync_memory_array.sv
// sync_memory_array: storage array with reset fill, synchronous write and combinational read
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset, fills every location with RESET_VALUE
//   addr    : shared write/read location
//   wr_en   : write strobe
//   wr_data : write data
//   rd_data : combinational content of mem[addr] (pre-write value in the write cycle)
module sync_memory_array
   import sync_memory_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = RESET_VALUE_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
      end else if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end
   assign rd_data = mem[addr];
endmodule

// File: rtl/sync_memory.sv
// sync_memory: single-port RAM, synchronous write, 1-cycle registered read, reset-filled contents
//   clk : rising-edge clock
//   rst : asynchronous active-low reset; contents -> RESET_VALUE, rd_data -> 0
//   bus : sync_memory_if slave (addr, wr_en, rd_en, wr_data in; rd_data out)
//   Build option SYNC_MEMORY_WR_FORWARD_EN: write-first on a simultaneous write+read,
//   otherwise read-first (rd_data gets the pre-write content).
module sync_memory
   import sync_memory_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = RESET_VALUE_DEF
) (
   input logic clk,
   input logic rst,
   sync_memory_if.slave bus
);
   logic [DATA_WIDTH-1:0] arr_data;
   logic [DATA_WIDTH-1:0] rd_next;
   logic [DATA_WIDTH-1:0] rd_q;
   sync_memory_array #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .RESET_VALUE(RESET_VALUE)
   ) u_array (
      .clk(clk),
      .rst(rst),
      .addr(bus.addr),
      .wr_en(bus.wr_en),
      .wr_data(bus.wr_data),
      .rd_data(arr_data)
   );
`ifdef SYNC_MEMORY_WR_FORWARD_EN
   // single shared address: any write in a read cycle targets the location being read
   assign rd_next = bus.wr_en ? bus.wr_data : arr_data;
`else
   assign rd_next = arr_data;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_q <= '0;
      else if (bus.rd_en) rd_q <= rd_next;
   end
   assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_sync_memory.sv
// tb_sync_memory: directed and random checks of sync_memory against an array reference model
module tb_sync_memory;
   import sync_memory_pkg::*;
`ifdef SYNC_MEMORY_WR_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   data_t model [DEPTH_DEF];
   data_t exp_rd;
   sync_memory_if #(.ADDR_WIDTH(ADDR_WIDTH_DEF), .DATA_WIDTH(DATA_WIDTH_DEF)) bus ();
   sync_memory #(
      .ADDR_WIDTH(ADDR_WIDTH_DEF),
      .DATA_WIDTH(DATA_WIDTH_DEF),
      .RESET_VALUE(8'hFF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input data_t obs, input data_t expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask
   task automatic model_reset();
      foreach (model[i]) model[i] = 8'hFF;
      exp_rd = 8'h00;
   endtask
   // one clock of traffic; the model applies the read rule before committing the write
   task automatic cycle(input bit w, input bit r, input addr_t a, input data_t d);
      @(negedge clk);
      bus.wr_en = w;
      bus.rd_en = r;
      bus.addr = a;
      bus.wr_data = d;
      @(posedge clk);
      if (r) exp_rd = (w && FWD) ? d : model[a];
      if (w) model[a] = d;
      #1;
   endtask
   initial begin
      bus.addr = '0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.wr_data = '0;
      model_reset();
      #1 rst = 1'b0;
      #2 check("reset_rd_data", bus.rd_data, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < DEPTH_DEF; i++) begin
         cycle(1'b0, 1'b1, addr_t'(i), 8'h00);
         check($sformatf("default_rd[%0d]", i), bus.rd_data, 8'hFF);
      end
      cycle(1'b1, 1'b0, 2'd2, 8'hA5);
      cycle(1'b0, 1'b1, 2'd2, 8'h00);
      check("wr_then_rd", bus.rd_data, 8'hA5);
      cycle(1'b0, 1'b1, 2'd1, 8'h00);
      check("rd_unwritten", bus.rd_data, 8'hFF);
      cycle(1'b0, 1'b1, 2'd2, 8'h00);
      check("rd_before_hold", bus.rd_data, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, addr_t'(i), 8'h00);
         check($sformatf("rd_hold[%0d]", i), bus.rd_data, 8'hA5);
      end
      cycle(1'b1, 1'b0, 2'd3, 8'h11);
      cycle(1'b1, 1'b1, 2'd3, 8'h22);
      check("simul_wr_rd", bus.rd_data, FWD ? 8'h22 : 8'h11);
      cycle(1'b0, 1'b1, 2'd3, 8'h00);
      check("after_simul", bus.rd_data, 8'h22);
      for (int i = 0; i < DEPTH_DEF; i++) cycle(1'b1, 1'b0, addr_t'(i), 8'h5A);
      cycle(1'b0, 1'b1, 2'd0, 8'h00);
      check("filled_rd", bus.rd_data, 8'h5A);
      // reset falls between edges while a write is presented; it must be discarded
      @(posedge clk);
      #2;
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.addr = 2'd1;
      bus.wr_data = 8'h77;
      rst = 1'b0;
      #1 check("async_rst_rd_data", bus.rd_data, 8'h00);
      model_reset();
      @(posedge clk);
      #1 check("rst_override", bus.rd_data, 8'h00);
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < DEPTH_DEF; i++) begin
         cycle(1'b0, 1'b1, addr_t'(i), 8'h00);
         check($sformatf("post_rst_rd[%0d]", i), bus.rd_data, 8'hFF);
      end
      for (int n = 0; n < 200; n++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               addr_t'($urandom_range(0, DEPTH_DEF - 1)), data_t'($urandom));
         check($sformatf("rand[%0d]", n), bus.rd_data, exp_rd);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
